imm_extend_stage: RTL and testbench

Parametrised, registered immediate-extension stage for the pipelined processor's decode path. It replaces the plain 16→32 combinational sign extension with a handshaked pipeline stage. The stage selects one of four extension modes per transaction, carries a tag alongside the data, and holds results through back-pressure using a 2-entry skid buffer. It sits between the decode register and the execute-stage operand mux, and it honours pipeline flushes.

---
 rtl/imm_extend_stage_if.sv | 32 +++
 rtl/imm_extend_stage.sv | 138 +++++++++++++
 tb/tb_imm_extend_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_stage_if.sv
// rtl/imm_extend_stage_if.sv - handshake bundle for the immediate-extension stage
//
// Groups the input (in_*) and output (out_*) stream signals of imm_extend_stage.
//   master : upstream decode register / downstream operand mux side
//            drives in_valid, in_data, in_mode, in_tag, out_ready
//   slave  : the extension stage itself
//            drives in_ready, out_valid, out_data, out_tag
interface imm_extend_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered, handshaked immediate extension with 2-entry skid buffer
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; drops all held results
//   flush  : synchronous pipeline flush; empties the stage and discards the
//            transaction offered in the same cycle
//   bus    : imm_extend_stage_if.slave
//            in_valid/in_ready/in_data/in_mode/in_tag   raw immediate in
//            out_valid/out_ready/out_data/out_tag       extended result out
// Modes: 00 sign, 01 zero, 10 branch (sign-extend then << 2), 11 upper.
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_extend_stage_if.slave   bus
);
    localparam int PAD_W = OUT_W - IN_W;

    // State encoding is {skid_valid, out_valid}; 2'b10 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [OUT_W-1:0] main_data, skid_data;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic [OUT_W-1:0] ext_data;

    logic out_valid, skid_valid, in_ready;
    logic accept, drain;
    logic load_main, load_skid, skid_to_main;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
        logic [OUT_W-1:0] sext;
        sext = {{PAD_W{d[IN_W-1]}}, d};
        case (m)
            2'b00:   extend = sext;
            2'b01:   extend = {{PAD_W{1'b0}}, d};
            2'b10:   extend = sext << 2;
            default: extend = {d, {PAD_W{1'b0}}};
        endcase
    endfunction

    assign ext_data   = extend(bus.in_data, bus.in_mode);

    assign out_valid  = state[0];
    assign skid_valid = state[1];
    // Comes straight from the state register, so it never depends on out_ready.
    assign in_ready   = !skid_valid;

    // An input offered during a flush is dropped, so it is never an accept.
    assign accept = bus.in_valid && in_ready && !flush;
    assign drain  = out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        // Main is stalled: park the new result behind it.
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (drain) begin
                        skid_to_main = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Main only loads when empty or draining, so out_data/out_tag hold
    // steady while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_tag  <= '0;
        end else if (load_main) begin
            main_data <= ext_data;
            main_tag  <= bus.in_tag;
        end else if (skid_to_main) begin
            main_data <= skid_data;
            main_tag  <= skid_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (load_skid) begin
            skid_data <= ext_data;
            skid_tag  <= bus.in_tag;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data;
    assign bus.out_tag   = main_tag;
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - self-checking bench for imm_extend_stage
module tb_imm_extend_stage;
    logic clk;
    logic rst_n;
    logic flush;
    logic flush12;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } item_t;

    item_t q[$];

    imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
    imm_extend_stage_if #(.IN_W(12), .OUT_W(20), .TAG_W(5)) bus12 ();

    imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    imm_extend_stage #(.IN_W(12), .OUT_W(20), .TAG_W(5)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush12),
        .bus   (bus12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic statement of the four extension rules.
    function automatic longint ref_ext(input int in_w, input int out_w, input longint d, input int m);
        longint mask;
        longint s;
        mask = (longint'(1) << out_w) - 1;
        s = d;
        if (d >= (longint'(1) << (in_w - 1))) s = d - (longint'(1) << in_w);
        case (m)
            0:       return s & mask;
            1:       return d;
            2:       return (s * 4) & mask;
            default: return (d * (longint'(1) << (out_w - in_w))) & mask;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(bus.out_data), 64'(q[0].data));
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
        end
    endtask

    // Advance one edge; the model is a queue of at most two pending results.
    task automatic tick();
        bit push;
        bit pop;
        item_t it;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            push = bus.in_valid && (q.size() < 2);
            pop  = bus.out_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) begin
                it.data = 32'(ref_ext(16, 32, longint'(bus.in_data), int'(bus.in_mode)));
                it.tag  = bus.in_tag;
                q.push_back(it);
            end
        end
        #1;
        compare_all();
    endtask

    task automatic offer(input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_tag   = t;
    endtask

    initial begin
        logic [15:0] mdata [5];
        logic [1:0]  mmode [5];
        logic [31:0] mexp  [5];
        logic [11:0] d12;
        logic [1:0]  m12;

        mdata = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF};
        mmode = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        mexp  = '{32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h80010000, 32'h00007FFF};

        rst_n         = 1'b0;
        flush         = 1'b0;
        flush12       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus12.in_valid  = 1'b0;
        bus12.in_data   = '0;
        bus12.in_mode   = '0;
        bus12.in_tag    = '0;
        bus12.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mode vectors
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(mdata[i], mmode[i], 5'(i));
            tick();
            chk("mode_vec", 64'(bus.out_data), 64'(mexp[i]));
        end
        bus.in_valid = 1'b0;
        tick();

        // Generic 12 -> 20 instance
        bus12.in_valid = 1'b1;
        bus12.in_data  = 12'h800;
        bus12.in_mode  = 2'b10;
        tick();
        chk("w12_branch", 64'(bus12.out_data), 64'h0FE000);
        bus12.in_mode  = 2'b11;
        tick();
        chk("w12_upper", 64'(bus12.out_data), 64'h080000);
        for (int i = 0; i < 8; i++) begin
            d12 = 12'($urandom);
            m12 = 2'($urandom);
            bus12.in_data = d12;
            bus12.in_mode = m12;
            tick();
            chk("w12_rand", 64'(bus12.out_data), 64'(ref_ext(12, 20, longint'(d12), int'(m12))));
        end
        bus12.in_valid = 1'b0;

        // Streaming: 8 back-to-back, one-cycle latency, tags in order
        for (int i = 0; i < 8; i++) begin
            offer(16'($urandom), 2'($urandom), 5'(i));
            tick();
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_tag", 64'(bus.out_tag), 64'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(bus.out_valid), 64'd0);

        // Back-pressure: three offers, two accepted
        bus.out_ready = 1'b0;
        offer(16'h1234, 2'b00, 5'd10);
        tick();
        chk("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
        offer(16'hF00F, 2'b10, 5'd11);
        tick();
        chk("bp_ready_after_2", 64'(bus.in_ready), 64'd0);
        offer(16'h00AA, 2'b11, 5'd12);
        tick();
        chk("bp_hold_tag", 64'(bus.out_tag), 64'd10);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_drain1_tag", 64'(bus.out_tag), 64'd11);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_drain2_tag", 64'(bus.out_tag), 64'd12);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Flush in FULL together with a new offer
        bus.out_ready = 1'b0;
        offer(16'h0001, 2'b00, 5'd20);
        tick();
        offer(16'h0002, 2'b00, 5'd21);
        tick();
        chk("fl_full", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        offer(16'h0003, 2'b00, 5'd22);
        tick();
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("fl_nothing", 64'(bus.out_valid), 64'd0);

        // Async reset mid-stream
        offer(16'h5555, 2'b01, 5'd3);
        tick();
        offer(16'h6666, 2'b01, 5'd4);
        tick();
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_out_data", 64'(bus.out_data), 64'd0);
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        #1;
        rst_n = 1'b1;
        offer(16'hABCD, 2'b01, 5'd7);
        tick();
        chk("ar_first_data", 64'(bus.out_data), 64'h0000ABCD);
        bus.in_valid = 1'b0;
        tick();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 16'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
